// File: rtl/vram_fetch.sv
// Slot-scheduled VRAM port: fetches two video words per character period and
// fills the remaining slots with single CPU byte accesses.
`timescale 1ns/1ps
module vram_fetch #(
  parameter int ADDR_W = 19,
  parameter int SLOTS  = 32
) (
  input  logic              clk_sys,
  input  logic              nRESET,
  input  logic              ce_24m,
  input  logic              char_start,
  input  logic [ADDR_W-1:0] vram_addr1,
  input  logic [ADDR_W-1:0] vram_addr2,
  output logic [15:0]       vram_dout1,
  output logic [15:0]       vram_dout2,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam int SW = $clog2(SLOTS);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOTS - 1);
  localparam logic [SW-1:0] SLOT_CPU0 = SW'(4);

  logic [SW-1:0]     slot;
  logic [SW-1:0]     slot_nxt;
  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic [ADDR_W-1:0] a1_nxt;
  logic              busy;
  logic              rd_pend;
  logic              issue;
  logic [7:0]        b0_p1;
  logic [7:0]        b1_p1;
  logic [7:0]        b2_p1;

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

  // Every action is keyed to the slot number the edge moves into.
  always_comb begin
    slot_nxt = slot + SW'(1);
    if (char_start || slot == SLOT_LAST) slot_nxt = '0;
    a1_nxt = char_start ? vram_addr1 : a1;
    issue  = cpu_req && !busy && (slot_nxt >= SLOT_CPU0);
  end

  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      slot       <= '0;
      a1         <= '0;
      a2         <= '0;
      vram_dout1 <= '0;
      vram_dout2 <= '0;
      cpu_rdata  <= '0;
      cpu_ack    <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      rd_pend    <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      if (ce_24m) begin
        slot   <= slot_nxt;
        mem_we <= 1'b0;
        if (char_start) begin
          a1 <= vram_addr1;
          a2 <= vram_addr2;
        end
        // A CPU op always completes on the ce after issue, whatever the slot.
        if (busy) begin
          busy    <= 1'b0;
          cpu_ack <= 1'b1;
          if (rd_pend) cpu_rdata <= mem_rdata;
        end else if (issue) begin
          busy      <= 1'b1;
          rd_pend   <= !cpu_we;
          mem_addr  <= cpu_addr;
          mem_we    <= cpu_we;
          mem_wdata <= cpu_wdata;
        end
        case (slot_nxt)
          SW'(0): mem_addr <= a1_nxt;
          SW'(1): mem_addr <= addr_inc(a1);
          SW'(2): mem_addr <= a2;
          SW'(3): mem_addr <= addr_inc(a2);
          SW'(4): begin
            vram_dout1 <= {b1_p1, b0_p1};
            vram_dout2 <= {mem_rdata, b2_p1};
          end
          default: ;
        endcase
      end
    end
  end

  // Video byte capture, one slot behind the address.
  always_ff @(posedge clk_sys) begin
    if (ce_24m) begin
      case (slot_nxt)
        SW'(1): b0_p1 <= mem_rdata;
        SW'(2): b1_p1 <= mem_rdata;
        SW'(3): b2_p1 <= mem_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/vram_fetch.md
Name: vram_fetch

Overview:
Slot-based VRAM access engine between the 512K video/system RAM and the video controller. Every character period (32 ce_24m slots), it fetches the two 16-bit words addressed by the video controller's vram_addr1/vram_addr2 and presents them as stable vram_dout1/vram_dout2. Remaining slots serve one CPU byte access at a time. Sits directly upstream of the video controller and drives the single byte-wide synchronous RAM port.

Parameters:
ADDR_W, 19, byte address width of RAM and video addresses
SLOTS, 32, ce_24m slots per character period; counter width is log2(SLOTS)

Ports:
clk_sys  in  1  master clock
nRESET  in  1  asynchronous active-low reset
ce_24m  in  1  slot clock enable
char_start  in  1  character boundary strobe; qualified by ce_24m; driven by top level one ce_24m after the video controller updates its addresses
vram_addr1  in  ADDR_W  video fetch address 1 (byte)
vram_addr2  in  ADDR_W  video fetch address 2 (byte)
vram_dout1  out  16  {mem[a1+1], mem[a1]}
vram_dout2  out  16  {mem[a2+1], mem[a2]}
cpu_req  in  1  level; CPU access request, held until cpu_ack
cpu_we  in  1  1=write, 0=read; sampled with cpu_req
cpu_addr  in  ADDR_W  CPU byte address
cpu_wdata  in  8  CPU write data
cpu_rdata  out  8  CPU read data, valid from cpu_ack onward
cpu_ack  out  1  one clk_sys pulse at completion
mem_addr  out  ADDR_W  RAM address (registered)
mem_we  out  1  RAM write strobe (registered)
mem_wdata  out  8  RAM write data
mem_rdata  in  8  RAM read data; valid at the ce_24m following the address

Behaviour:
- Reset (async, nRESET=0): slot=0, a1/a2 latches=0, vram_dout1/2=0, cpu_rdata=0, cpu_ack=0, mem_addr=0, mem_we=0, mem_wdata=0, no CPU op in flight.
- All state advances only on clk_sys edges with ce_24m=1. The exception is cpu_ack, which drops on the next clk_sys edge.
- Slot counter: increments each ce_24m and wraps SLOTS-1 -> 0. If char_start=1 with ce_24m, slot is forced to 0, and vram_addr1/2 are latched into a1/a2 on that same edge.
- Video schedule, with mem_addr registered at slot n and data captured at slot n+1:
  - slot0: addr=a1
  - slot1: addr=a1+1, capture b0
  - slot2: addr=a2, capture b1
  - slot3: addr=a2+1, capture b2
  - slot4: capture b3; publish vram_dout1={b1,b0} and vram_dout2={b3,b2} atomically on this edge.
  - Increments are modulo 2^ADDR_W: 7FFFF+1 -> 00000.
- Publish only at slot 4. If char_start restarts the sequence at slots 1–4, partial bytes are discarded and the previously published outputs hold.
- mem_we is always 0 during video slots 0–3.
- CPU issue: allowed in slots 4..SLOTS-1 when cpu_req=1 and no op is in flight.
  - Issue edge: mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata; the op is marked in flight.
  - Completion at the next ce_24m: mem_we=0; for reads, cpu_rdata=mem_rdata; cpu_ack=1 for one clk_sys.
  - Completion always occurs at the next ce_24m, even if that edge is slot 0 or char_start forces slot 0. The video address driven on that edge is unaffected.
- CPU requester rules:
  - Must deassert cpu_req or change the request after seeing cpu_ack.
  - If cpu_req is still high on the ack edge, the new request may issue no earlier than the following slot.
  - If cpu_req falls before issue, nothing happens. Once issued, the op completes regardless of cpu_req.
- Throughput: at most one CPU op every 2 slots, i.e. max 14 per character with SLOTS=32.
- A CPU request pending at slot 0..3 waits until slot 4; video always has priority.
- Reset asserted mid-operation aborts the in-flight op with no ack. A held cpu_req is served after release.

Test Plan:
- Preload mem[0x00100..0x00103]=11,22,33,44; vram_addr1=0x00100, vram_addr2=0x00102; pulse char_start -> at slot 4 vram_dout1=0x2211, vram_dout2=0x4433; both outputs change on the same edge and are stable through slot 3 of the next character.
- vram_addr1=0x7FFFF with mem[0x7FFFF]=AA, mem[0x00000]=BB -> vram_dout1=0xBBAA.
- CPU write 0x5A to 0x01234 requested at slot 1 -> mem_we high only for the slot-4 issue edge; cpu_ack at slot 5; later CPU read of 0x01234 returns cpu_rdata=0x5A.
- CPU read issued at slot 31, then char_start at the next ce_24m -> cpu_ack on that edge with the correct data; slot-0 mem_addr=a1; video fetch unaffected.
- char_start at slot 2, then again 32 slots later with new addresses -> no publish from the aborted sequence; old dout held until slot 4 of the restarted sequence.
- nRESET pulsed low mid CPU read at slot 10 -> all outputs 0 immediately, no cpu_ack; after release, the held cpu_req is served at the first slot >=4.
